// File: rtl/axi_budget_regulator.sv
`default_nettype none
// ============================================================================
// Module   : axi_budget_regulator
// Purpose  : Per-master AXI bandwidth regulator. Gates each master's AW/AR
//            address handshakes against a beat budget that is reloaded once
//            per regulation period. W, R and B channels are untouched, and the
//            address payload bypasses this block.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            enable_i                1 = regulate, 0 = transparent
//            period_i                regulation period in cycles (0 -> 1)
//            budget_w_i/budget_r_i   per-master beat budgets, packed
//            mst_a{w,r}_valid_i      address valid from master m
//            mst_a{w,r}_len_i        burst len of the pending request, packed
//            mst_a{w,r}_ready_o      address ready back to master m
//            xbar_a{w,r}_valid_o     gated valid to crossbar slave port m
//            xbar_a{w,r}_ready_i     ready from crossbar slave port m
//            stall_o                 master m has a valid blocked by budget
//            credit_w_o/credit_r_o   remaining credit per master, packed
// Revision : 1.0 - initial release
// ============================================================================
module axi_budget_regulator #(
  parameter int NoMasters   = 4,
  parameter int PeriodWidth = 16,
  parameter int BudgetWidth = 16,
  parameter int LenWidth    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [PeriodWidth-1:0]           period_i,
  input  logic [NoMasters*BudgetWidth-1:0] budget_w_i,
  input  logic [NoMasters*BudgetWidth-1:0] budget_r_i,
  input  logic [NoMasters-1:0]             mst_aw_valid_i,
  input  logic [NoMasters-1:0]             mst_ar_valid_i,
  input  logic [NoMasters*LenWidth-1:0]    mst_aw_len_i,
  input  logic [NoMasters*LenWidth-1:0]    mst_ar_len_i,
  output logic [NoMasters-1:0]             mst_aw_ready_o,
  output logic [NoMasters-1:0]             mst_ar_ready_o,
  output logic [NoMasters-1:0]             xbar_aw_valid_o,
  output logic [NoMasters-1:0]             xbar_ar_valid_o,
  input  logic [NoMasters-1:0]             xbar_aw_ready_i,
  input  logic [NoMasters-1:0]             xbar_ar_ready_i,
  output logic [NoMasters-1:0]             stall_o,
  output logic [NoMasters*BudgetWidth-1:0] credit_w_o,
  output logic [NoMasters*BudgetWidth-1:0] credit_r_o
);

  // len+1 needs one extra bit so that len=all-ones costs 2**LenWidth beats.
  localparam int CostWidth = LenWidth + 1;

  logic [PeriodWidth-1:0] cnt_q;
  logic [PeriodWidth-1:0] period_eff;
  logic                   replenish;

  assign period_eff = (period_i == '0) ? PeriodWidth'(1) : period_i;
  assign replenish  = (cnt_q == '0);

  // The >= compare (rather than ==) makes a lowered period take effect at
  // once instead of letting cnt run all the way round the counter range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!enable_i || (cnt_q >= period_eff - PeriodWidth'(1))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PeriodWidth'(1);
    end
  end

  for (genvar m = 0; m < NoMasters; m++) begin : g_mst
    // Channel 0 is AW (write pool), channel 1 is AR (read pool).
    for (genvar c = 0; c < 2; c++) begin : g_chan
      logic                   valid;
      logic                   xready;
      logic [LenWidth-1:0]    len;
      logic [BudgetWidth-1:0] budget;
      logic [CostWidth-1:0]   cost;
      logic [BudgetWidth-1:0] cost_ext;
      logic [BudgetWidth-1:0] base;
      logic [BudgetWidth-1:0] debit;
      logic [BudgetWidth-1:0] credit_q;
      logic                   granted_q;
      logic                   elig;
      logic                   xvalid;
      logic                   hs;

      assign valid  = (c == 0) ? mst_aw_valid_i[m] : mst_ar_valid_i[m];
      assign xready = (c == 0) ? xbar_aw_ready_i[m] : xbar_ar_ready_i[m];
      assign len    = (c == 0) ? mst_aw_len_i[m*LenWidth +: LenWidth]
                               : mst_ar_len_i[m*LenWidth +: LenWidth];
      assign budget = (c == 0) ? budget_w_i[m*BudgetWidth +: BudgetWidth]
                               : budget_r_i[m*BudgetWidth +: BudgetWidth];

      assign cost     = {1'b0, len} + CostWidth'(1);
      assign cost_ext = BudgetWidth'(cost);

      // A grant already presented to the crossbar stays eligible so the
      // valid is never withdrawn before its handshake.
      assign elig   = !enable_i || granted_q || (credit_q >= cost_ext);
      assign xvalid = valid & elig;
      assign hs     = xvalid & xready;

      // Unused credit is discarded at replenish; disabled mode keeps the
      // credit parked at the full budget.
      assign base  = (!enable_i || replenish) ? budget : credit_q;
      assign debit = (enable_i && hs) ? cost_ext : '0;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          credit_q  <= '0;
          granted_q <= 1'b0;
        end else begin
          credit_q <= (base > debit) ? (base - debit) : '0;
          if (hs) begin
            granted_q <= 1'b0;
          end else if (xvalid) begin
            granted_q <= 1'b1;
          end
        end
      end
    end

    assign xbar_aw_valid_o[m] = g_chan[0].xvalid;
    assign xbar_ar_valid_o[m] = g_chan[1].xvalid;
    assign mst_aw_ready_o[m]  = g_chan[0].xready & g_chan[0].elig;
    assign mst_ar_ready_o[m]  = g_chan[1].xready & g_chan[1].elig;
    assign stall_o[m]         = (g_chan[0].valid & ~g_chan[0].elig) |
                                (g_chan[1].valid & ~g_chan[1].elig);
    assign credit_w_o[m*BudgetWidth +: BudgetWidth] = g_chan[0].credit_q;
    assign credit_r_o[m*BudgetWidth +: BudgetWidth] = g_chan[1].credit_q;
  end

endmodule
`default_nettype wire
